// File: rtl/output_vc_status_tracker_pkg.sv
// Shared definitions for the output-VC status tracker.
// Provides the credit counter width helper, realloc policy names and the credit-update opcode.
package output_vc_status_tracker_pkg;

  localparam string REALLOC_CONSERV = "CONSERV";
  localparam string REALLOC_ATOMIC  = "ATOMIC";

  typedef enum logic [1:0] {
    CR_HOLD = 2'd0,
    CR_DEC  = 2'd1,
    CR_INC  = 2'd2
  } credit_op_e;

  // Counter must hold 0..depth inclusive
  function automatic int calc_cw(input int depth);
    return $clog2(depth + 1);
  endfunction

  // A send and a credit in the same cycle cancel out
  function automatic credit_op_e credit_op(input logic sent, input logic credit);
    if (sent && !credit) return CR_DEC;
    if (credit && !sent) return CR_INC;
    return CR_HOLD;
  endfunction

endpackage

// File: rtl/output_vc_status_tracker_ovc_credit_counter.sv
// One output VC: downstream credit counter, allocation flag and error flags.
// Every input event is reflected on the outputs one cycle later; no input-to-output path.
module ovc_credit_counter
  import output_vc_status_tracker_pkg::*;
#(
  parameter int B        = 4,
  parameter int CW       = calc_cw(4),
  parameter bit ATOMIC   = 1'b0,
  parameter bit DEBUG_EN = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alloc,
  input  logic          sent,
  input  logic          tail,
  input  logic          credit,
  output logic [CW-1:0] cnt,
  output logic          avail,
  output logic          not_full,
  output logic          err_underflow,
  output logic          err_overflow,
  output logic          err_realloc
);

  localparam logic [CW-1:0] FULL = CW'(B);

  credit_op_e op;
  logic       clr;
  logic       alloc_flag;

  assign op  = credit_op(sent, credit);
  assign clr = sent & tail;

  // Saturating credit counter; an out-of-range event holds the value and flags an error
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt           <= FULL;
      err_underflow <= 1'b0;
      err_overflow  <= 1'b0;
    end else begin
      err_underflow <= 1'b0;
      err_overflow  <= 1'b0;
      case (op)
        CR_DEC: begin
          if (cnt == '0) err_underflow <= DEBUG_EN;
          else           cnt <= cnt - CW'(1);
        end
        CR_INC: begin
          if (cnt == FULL) err_overflow <= DEBUG_EN;
          else             cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Allocation flag; a tail send wins over a same-cycle alloc (single-flit packet)
  always_ff @(posedge clk) begin
    if (reset) begin
      alloc_flag  <= 1'b0;
      err_realloc <= 1'b0;
    end else begin
      err_realloc <= 1'b0;
      if (alloc && !clr) begin
        alloc_flag  <= 1'b1;
        err_realloc <= DEBUG_EN & alloc_flag;
      end else if (clr) begin
        alloc_flag  <= 1'b0;
      end
    end
  end

  assign not_full = (cnt != '0);
  assign avail    = ~alloc_flag & (ATOMIC ? (cnt != '0) : (cnt == FULL));

endmodule

// File: rtl/output_vc_status_tracker.sv
// Per-output-port OVC state keeper feeding the VC/switch allocator masks.
// Outputs derive from registered state only; events show up one cycle later. No backpressure.
module output_vc_status_tracker
  import output_vc_status_tracker_pkg::*;
#(
  parameter int    V        = 4,
  parameter int    B        = 4,
  parameter string REALLOC  = "CONSERV",
  parameter bit    DEBUG_EN = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [V-1:0]              ovc_alloc_in,
  input  logic [V-1:0]              flit_sent_in,
  input  logic                      flit_sent_tail,
  input  logic [V-1:0]              credit_in,
  output logic [V-1:0]              ovc_avail,
  output logic [V-1:0]              ovc_not_full,
  output logic [V*calc_cw(B)-1:0]   credit_cnt_all,
  output logic                      err_underflow,
  output logic                      err_overflow,
  output logic                      err_realloc
);

  localparam int CW        = calc_cw(B);
  // Unrecognised policy names fall back to the conservative policy
  localparam bit IS_ATOMIC = (REALLOC == REALLOC_ATOMIC);

  logic [V-1:0] eu;
  logic [V-1:0] eo;
  logic [V-1:0] er;

  for (genvar v = 0; v < V; v++) begin : g_vc
    ovc_credit_counter #(
      .B        (B),
      .CW       (CW),
      .ATOMIC   (IS_ATOMIC),
      .DEBUG_EN (DEBUG_EN)
    ) u_vc (
      .clk           (clk),
      .reset         (reset),
      .alloc         (ovc_alloc_in[v]),
      .sent          (flit_sent_in[v]),
      .tail          (flit_sent_tail),
      .credit        (credit_in[v]),
      .cnt           (credit_cnt_all[v*CW +: CW]),
      .avail         (ovc_avail[v]),
      .not_full      (ovc_not_full[v]),
      .err_underflow (eu[v]),
      .err_overflow  (eo[v]),
      .err_realloc   (er[v])
    );
  end

  assign err_underflow = |eu;
  assign err_overflow  = |eo;
  assign err_realloc   = |er;

endmodule
